// File: rtl/interact_bank.sv
// interact_bank: strided APF bridge settings bank with read-back, per-register
// change strobes and a programmable core-reset pulse generator (clk_74a domain).
// Optional build macro INTERACT_BANK_SHADOW_EN: data writes go to shadows and
// are committed to live by a command write with bit1 set; command bit0 forces
// a reset pulse. Without the macro, writes go straight to live and any command
// write forces a reset pulse.

// One register slot: live value, optional shadow, change strobe, reset trigger.
module interact_bank_slot #(
    parameter int REG_W  = 32,
    parameter bit RST_EN = 1'b1
) (
    input  logic             clk_74a,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             commit,
    input  logic [REG_W-1:0] wr_data,
    output logic [REG_W-1:0] live_q,
    output logic [REG_W-1:0] rd_val,
    output logic             changed_q,
    output logic             trig
);
`ifdef INTERACT_BANK_SHADOW_EN
    logic [REG_W-1:0] shadow_q;
    logic             pend_q;

    // Capture writes into the shadow; move pending shadow to live on commit.
    // A commit and a data write never coincide: they decode to different
    // addresses of the same single-access bus.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            live_q    <= '0;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (commit && pend_q) begin
                live_q    <= shadow_q;
                changed_q <= 1'b1;
                pend_q    <= 1'b0;
            end
            if (wr_en) begin
                shadow_q <= wr_data;
                pend_q   <= 1'b1;
            end
        end
    end

    // Host reads see what it last wrote, committed or not.
    assign rd_val = shadow_q;
    assign trig   = RST_EN && commit && pend_q;
`else
    logic unused_commit;
    assign unused_commit = commit;

    // Writes land directly in live; strobe fires even if the value is unchanged.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            live_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= wr_en;
            if (wr_en) live_q <= wr_data;
        end
    end

    assign rd_val = live_q;
    assign trig   = RST_EN && wr_en;
`endif
endmodule

module interact_bank #(
    parameter int                  NUM_REGS     = 8,
    parameter int                  REG_W        = 32,
    parameter logic [31:0]         ADDR_BASE    = 32'hF000_0000,
    parameter int                  STRIDE_LOG2  = 24,
    parameter logic [NUM_REGS-1:0] RESET_MASK   = '1,
    parameter int                  RESET_CYCLES = 8000
) (
    input  logic                      clk_74a,
    input  logic                      reset,
    input  logic [31:0]               bridge_addr,
    input  logic                      bridge_wr,
    input  logic [31:0]               bridge_wr_data,
    input  logic                      bridge_rd,
    output logic [31:0]               bridge_rd_data,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]       reg_changed,
    output logic                      core_reset_req
);
    localparam logic [31:0] STRIDE_MASK = (32'd1 << STRIDE_LOG2) - 32'd1;
    localparam logic [23:0] RST_LOAD    = 24'(RESET_CYCLES);

    logic [31:0]                    off;
    logic [31:0]                    idx;
    logic                           hit;
    logic                           cmd_wr;
    logic                           commit;
    logic                           trigger;
    logic [NUM_REGS-1:0]            slot_wr;
    logic [NUM_REGS-1:0]            slot_trig;
    logic [NUM_REGS-1:0]            slot_chg;
    logic [NUM_REGS-1:0][REG_W-1:0] slot_live;
    logic [NUM_REGS-1:0][REG_W-1:0] slot_rd;
    logic [23:0]                    rst_cnt_q;
    logic [31:0]                    rd_next;
    logic [31:0]                    rd_q;
    logic                           unused_wr_data;

    // Window decode: aligned to the stride and inside command + data slots.
    // Addresses below the base wrap to huge offsets and miss.
    assign off    = bridge_addr - ADDR_BASE;
    assign idx    = off >> STRIDE_LOG2;
    assign hit    = ((off & STRIDE_MASK) == 32'd0) && (idx < 32'(NUM_REGS + 1));
    assign cmd_wr = bridge_wr && hit && (idx == 32'd0);

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_slot
            assign slot_wr[i] = bridge_wr && hit && (idx == 32'(i + 1));

            interact_bank_slot #(
                .REG_W (REG_W),
                .RST_EN(RESET_MASK[i])
            ) u_slot (
                .clk_74a  (clk_74a),
                .reset    (reset),
                .wr_en    (slot_wr[i]),
                .commit   (commit),
                .wr_data  (bridge_wr_data[REG_W-1:0]),
                .live_q   (slot_live[i]),
                .rd_val   (slot_rd[i]),
                .changed_q(slot_chg[i]),
                .trig     (slot_trig[i])
            );
        end
    endgenerate

`ifdef INTERACT_BANK_SHADOW_EN
    assign commit  = cmd_wr && bridge_wr_data[1];
    assign trigger = (cmd_wr && bridge_wr_data[0]) || (|slot_trig);
`else
    assign commit  = 1'b0;
    assign trigger = cmd_wr || (|slot_trig);
`endif

    // Upper write-data bits only matter for wide registers / command bits.
    assign unused_wr_data = ^bridge_wr_data;

    // Reset pulse counter: trigger (re)loads, otherwise count down to zero.
    always_ff @(posedge clk_74a) begin
        if (reset)                rst_cnt_q <= '0;
        else if (trigger)         rst_cnt_q <= RST_LOAD;
        else if (rst_cnt_q != '0) rst_cnt_q <= rst_cnt_q - 24'd1;
    end

    assign core_reset_req = (rst_cnt_q != '0);

    // Read mux from current (pre-write) state; misses return zero.
    always_comb begin
        rd_next = 32'd0;
        if (hit) begin
            if (idx == 32'd0) rd_next = {31'b0, core_reset_req};
            for (int k = 0; k < NUM_REGS; k++)
                if (idx == 32'(k + 1)) rd_next = 32'(slot_rd[k]);
        end
    end

    // Registered read data, held while no read is issued.
    always_ff @(posedge clk_74a) begin
        if (reset)          rd_q <= 32'd0;
        else if (bridge_rd) rd_q <= rd_next;
    end

    assign bridge_rd_data = rd_q;
    assign regs_flat      = slot_live;
    assign reg_changed    = slot_chg;
endmodule

// File: tb/tb_interact_bank.sv
// Bench for interact_bank: a default instance (a_*) and a narrow instance
// with REG_W=4, RESET_MASK=8'hFE, RESET_CYCLES=20 (b_*). Read expectations
// go through a scoreboard queue. Shadow-mode sequences are selected by
// INTERACT_BANK_SHADOW_EN.
module tb_interact_bank;
    logic clk_74a = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_74a = ~clk_74a;

    logic [31:0]  a_addr, a_wdata, a_rdata;
    logic         a_wr, a_rd, a_req;
    logic [255:0] a_regs;
    logic [7:0]   a_chg;

    logic [31:0]  b_addr, b_wdata, b_rdata;
    logic         b_wr, b_rd, b_req;
    logic [31:0]  b_regs;
    logic [7:0]   b_chg;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t sb[$];

    localparam logic [31:0] CMD = 32'hF000_0000;

    interact_bank dut_a (
        .clk_74a(clk_74a), .reset(reset),
        .bridge_addr(a_addr), .bridge_wr(a_wr), .bridge_wr_data(a_wdata),
        .bridge_rd(a_rd), .bridge_rd_data(a_rdata),
        .regs_flat(a_regs), .reg_changed(a_chg), .core_reset_req(a_req)
    );

    interact_bank #(.REG_W(4), .RESET_MASK(8'hFE), .RESET_CYCLES(20)) dut_b (
        .clk_74a(clk_74a), .reset(reset),
        .bridge_addr(b_addr), .bridge_wr(b_wr), .bridge_wr_data(b_wdata),
        .bridge_rd(b_rd), .bridge_rd_data(b_rdata),
        .regs_flat(b_regs), .reg_changed(b_chg), .core_reset_req(b_req)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        a_wr = 1'b0; a_rd = 1'b0;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic drive(input bit sel, input logic [31:0] addr, input logic w,
                         input logic [31:0] d, input logic r);
        if (!sel) begin a_addr = addr; a_wr = w; a_wdata = d; a_rd = r; end
        else      begin b_addr = addr; b_wr = w; b_wdata = d; b_rd = r; end
    endtask

    // Called at a negedge; returns at the negedge after the capturing edge.
    task automatic bus_wr(input bit sel, input logic [31:0] addr, input logic [31:0] d);
        drive(sel, addr, 1'b1, d, 1'b0);
        @(negedge clk_74a);
        idle_bus();
    endtask

    task automatic bus_rdwr(input bit sel, input logic [31:0] addr, input logic w,
                            input logic [31:0] d, input logic [31:0] exp, input string tag);
        rd_exp_t e;
        e.tag = tag; e.exp = exp;
        sb.push_back(e);
        drive(sel, addr, w, d, 1'b1);
        @(negedge clk_74a);
        idle_bus();
        e = sb.pop_front();
        chk(e.tag, {224'b0, sel ? b_rdata : a_rdata}, {224'b0, e.exp});
    endtask

    task automatic bus_rd(input bit sel, input logic [31:0] addr, input logic [31:0] exp,
                          input string tag);
        bus_rdwr(sel, addr, 1'b0, 32'h0, exp, tag);
    endtask

    task automatic count_pulse(input bit sel, output int n);
        n = 0;
        while ((sel ? b_req : a_req) && n < 20000) begin
            n++;
            @(negedge clk_74a);
        end
        if (n >= 20000) chk("pulse_timeout", {255'b0, sel ? b_req : a_req}, 256'd0);
    endtask

    initial begin
        int n, hi, lo;
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
        idle_bus();
        reset = 1'b1;
        @(negedge clk_74a);
        @(negedge clk_74a);
        chk("rst_a_regs", a_regs, 256'd0);
        chk("rst_a_chg", {248'b0, a_chg}, 256'd0);
        chk("rst_a_req", {255'b0, a_req}, 256'd0);
        chk("rst_a_rd", {224'b0, a_rdata}, 256'd0);
        chk("rst_b_regs", {224'b0, b_regs}, 256'd0);
        chk("rst_b_req", {255'b0, b_req}, 256'd0);
        reset = 1'b0;
        @(negedge clk_74a);

`ifdef INTERACT_BANK_SHADOW_EN
        bus_wr(0, 32'hF100_0000, 32'hA);
        bus_wr(0, 32'hF400_0000, 32'hB);
        chk("shd_live_held", a_regs, 256'd0);
        chk("shd_no_chg", {248'b0, a_chg}, 256'd0);
        chk("shd_no_req", {255'b0, a_req}, 256'd0);
        bus_rd(0, 32'hF100_0000, 32'hA, "shd_rd_shadow");
        bus_wr(0, CMD, 32'h0);
        chk("shd_cmd0_live", a_regs, 256'd0);
        chk("shd_cmd0_req", {255'b0, a_req}, 256'd0);
        bus_wr(0, CMD, 32'h2);
        chk("shd_commit_r0", {224'b0, a_regs[31:0]}, 256'hA);
        chk("shd_commit_r3", {224'b0, a_regs[127:96]}, 256'hB);
        chk("shd_commit_chg", {248'b0, a_chg}, 256'h09);
        chk("shd_commit_req", {255'b0, a_req}, 256'd1);
        @(negedge clk_74a);
        chk("shd_chg_1cyc", {248'b0, a_chg}, 256'd0);
        bus_wr(1, 32'hF100_0000, 32'h5);
        bus_wr(1, CMD, 32'h2);
        chk("shd_b_commit", {252'b0, b_regs[3:0]}, 256'h5);
        chk("shd_b_chg", {248'b0, b_chg}, 256'h01);
        chk("shd_b_masked", {255'b0, b_req}, 256'd0);
        bus_wr(1, CMD, 32'h1);
        chk("shd_b_bit0", {255'b0, b_req}, 256'd1);
`else
        bus_wr(0, 32'hF200_0000, 32'hDEAD_BEEF);
        chk("wr_reg1", {224'b0, a_regs[63:32]}, 256'hDEAD_BEEF);
        chk("wr_reg0_untouched", {224'b0, a_regs[31:0]}, 256'd0);
        chk("wr_chg", {248'b0, a_chg}, 256'h02);
        chk("wr_req_rise", {255'b0, a_req}, 256'd1);
        @(negedge clk_74a);
        chk("wr_chg_1cyc", {248'b0, a_chg}, 256'd0);
        count_pulse(0, n);
        chk("pulse_len", 256'(1 + n), 256'd8000);
        bus_rd(0, CMD, 32'h0, "rd_cmd_idle");
        bus_rd(0, 32'hF200_0000, 32'hDEAD_BEEF, "rd_reg1");
        @(negedge clk_74a);
        chk("rd_hold", {224'b0, a_rdata}, 256'hDEAD_BEEF);
        bus_wr(0, 32'hF900_0000, 32'h123);
        chk("oob_wr_chg", {248'b0, a_chg}, 256'd0);
        bus_wr(0, 32'hF000_0010, 32'h1);
        chk("oob_wr_req", {255'b0, a_req}, 256'd0);
        chk("oob_wr_regs", a_regs, {192'b0, 32'hDEAD_BEEF, 32'h0});

        bus_wr(1, 32'hF100_0000, 32'h5);
        chk("b_reg0", {252'b0, b_regs[3:0]}, 256'h5);
        chk("b_chg0", {248'b0, b_chg}, 256'h01);
        chk("b_masked_req", {255'b0, b_req}, 256'd0);
        bus_rd(1, CMD, 32'h0, "b_rd_cmd");
        bus_wr(1, 32'hF300_0000, 32'hFFFF_FFF3);
        chk("b_reg2_trunc", {252'b0, b_regs[11:8]}, 256'h3);
        chk("b_reg2_req", {255'b0, b_req}, 256'd1);
        bus_rd(1, 32'hF300_0000, 32'h3, "b_rd_reg2");
        bus_rdwr(1, 32'hF300_0000, 1'b1, 32'h7, 32'h3, "b_rdwr_pre");
        bus_rd(1, 32'hF300_0000, 32'h7, "b_rd_post");
        bus_rd(1, CMD, 32'h1, "b_rd_cmd_busy");
`endif

        // Out-of-window reads return zero even after a nonzero read.
        bus_rd(0, 32'hF900_0000, 32'h0, "oob_rd_idx9");
        bus_rd(0, 32'hF000_0010, 32'h0, "oob_rd_unaligned");

        // Re-trigger 3000 cycles into a pulse extends it to 11000 total.
        count_pulse(0, n);
        bus_wr(0, CMD, 32'h1);
        hi = 0; lo = 0;
        for (int k = 0; k < 3000; k++) begin
            if (a_req) hi++; else lo++;
            if (k < 2999) @(negedge clk_74a);
        end
        bus_wr(0, CMD, 32'h1);
        count_pulse(0, n);
        chk("ext_len", 256'(hi + n), 256'd11000);
        chk("ext_gap", 256'(lo), 256'd0);

        // Reset in the middle of a pulse aborts it and clears everything.
        bus_wr(0, CMD, 32'h1);
        bus_rd(0, CMD, 32'h1, "rd_cmd_busy");
        repeat (3) @(negedge clk_74a);
        chk("mid_req_before", {255'b0, a_req}, 256'd1);
        reset = 1'b1;
        @(negedge clk_74a);
        chk("mid_rst_req", {255'b0, a_req}, 256'd0);
        chk("mid_rst_regs", a_regs, 256'd0);
        chk("mid_rst_chg", {248'b0, a_chg}, 256'd0);
        chk("mid_rst_rd", {224'b0, a_rdata}, 256'd0);
        chk("mid_rst_b_regs", {224'b0, b_regs}, 256'd0);
        reset = 1'b0;
        @(negedge clk_74a);
        chk("mid_rst_stays_low", {255'b0, a_req}, 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
